// File: rtl/icb_dds_multi.sv
// NCH-channel DDS behind an ICB slave; channel settings are shadowed and committed together via APPLY.
// Optional per-channel frequency sweep (STEP/LIMIT, CTRL bit3) is built in when DDS_SWEEP_EN is defined.
module icb_dds_multi #(
  parameter int NCH = 2,
  parameter int PW  = 32,
  parameter int DW  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              dds_icb_cmd_valid,
  output logic              dds_icb_cmd_ready,
  input  logic [31:0]       dds_icb_cmd_addr,
  input  logic              dds_icb_cmd_read,
  input  logic [31:0]       dds_icb_cmd_wdata,
  input  logic [3:0]        dds_icb_cmd_wmask,
  output logic              dds_icb_rsp_valid,
  input  logic              dds_icb_rsp_ready,
  output logic              dds_icb_rsp_err,
  output logic [31:0]       dds_icb_rsp_rdata,
  output logic [NCH*DW-1:0] dac_data
);

`ifdef DDS_SWEEP_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif
  localparam int SW = DW + 1;
  localparam logic [DW:0] AMP_ONE = {1'b1, {DW{1'b0}}};

  logic [CW-1:0]   ctrl_sh  [NCH];
  logic [CW-1:0]   ctrl_act [NCH];
  logic [PW-1:0]   freq_sh  [NCH];
  logic [PW-1:0]   freq_act [NCH];
  logic [PW-1:0]   phase_sh [NCH];
  logic [DW:0]     amp_sh   [NCH];
  logic [DW:0]     amp_act  [NCH];
  logic [PW-1:0]   acc      [NCH];
  logic [DW-1:0]   wave_q   [NCH];
  logic [DW-1:0]   dac_q    [NCH];
  logic [2*DW:0]   prod     [NCH];
  logic [DW:0]     scaled   [NCH];

  logic            accept;
  logic            wr_en;
  logic            dec_err;
  logic            apply_hit;
  logic [31:0]     dec_rdata;
  logic [NCH-1:0]  wr_ctrl, wr_freq, wr_phase, wr_amp;
  logic [NCH-1:0]  en_vec;
  logic [NCH-1:0]  commit;
  logic            unused_bits;

`ifdef DDS_SWEEP_EN
  logic [9:0]      sweep_cnt;
  logic            sweep_tick;
  logic [NCH-1:0]  wr_step, wr_limit;
  logic [NCH-1:0]  sweep_wrap;
  logic [PW-1:0]   step_sh   [NCH];
  logic [PW-1:0]   step_act  [NCH];
  logic [PW-1:0]   limit_sh  [NCH];
  logic [PW-1:0]   limit_act [NCH];
  logic [PW-1:0]   freq_base [NCH];
  logic [PW-1:0]   freq_next [NCH];

  assign sweep_tick = (sweep_cnt == '1);

  // A sweep step that passes LIMIT in its own direction falls back to the committed FREQ.
  always_comb begin
    sweep_wrap = '0;
    for (int c = 0; c < NCH; c++) begin
      freq_next[c]  = freq_act[c] + step_act[c];
      sweep_wrap[c] = step_act[c][PW-1] ? (freq_next[c] < limit_act[c])
                                        : ((step_act[c] != '0) && (freq_next[c] > limit_act[c]));
    end
  end
`endif

  assign unused_bits       = ^{dds_icb_cmd_wmask, dds_icb_cmd_addr[31:9]};
  assign dds_icb_cmd_ready = ~dds_icb_rsp_valid | dds_icb_rsp_ready;
  assign accept            = dds_icb_cmd_valid & dds_icb_cmd_ready;
  assign wr_en             = accept & ~dds_icb_cmd_read & ~dec_err;
  assign commit            = {NCH{wr_en & apply_hit}} & dds_icb_cmd_wdata[NCH-1:0];

  always_comb begin
    dec_err   = 1'b1;
    dec_rdata = '0;
    apply_hit = 1'b0;
    wr_ctrl   = '0;
    wr_freq   = '0;
    wr_phase  = '0;
    wr_amp    = '0;
    en_vec    = '0;
`ifdef DDS_SWEEP_EN
    wr_step   = '0;
    wr_limit  = '0;
`endif
    for (int c = 0; c < NCH; c++) en_vec[c] = ctrl_act[c][0];
    if (dds_icb_cmd_addr[8]) begin
      if (dds_icb_cmd_addr[7:0] == 8'h00) begin
        dec_err   = 1'b0;
        apply_hit = 1'b1;
      end else if (dds_icb_cmd_addr[7:0] == 8'h04) begin
        dec_err              = ~dds_icb_cmd_read;
        dec_rdata[NCH-1:0]   = en_vec;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (dds_icb_cmd_addr[7:5] == 3'(c)) begin
          case (dds_icb_cmd_addr[4:0])
            5'h00: begin dec_err = 1'b0; dec_rdata[CW-1:0] = ctrl_sh[c];  wr_ctrl[c]  = 1'b1; end
            5'h04: begin dec_err = 1'b0; dec_rdata[PW-1:0] = freq_sh[c];  wr_freq[c]  = 1'b1; end
            5'h08: begin dec_err = 1'b0; dec_rdata[PW-1:0] = phase_sh[c]; wr_phase[c] = 1'b1; end
            5'h0C: begin dec_err = 1'b0; dec_rdata[DW:0]   = amp_sh[c];   wr_amp[c]   = 1'b1; end
`ifdef DDS_SWEEP_EN
            5'h10: begin dec_err = 1'b0; dec_rdata[PW-1:0] = step_sh[c];  wr_step[c]  = 1'b1; end
            5'h14: begin dec_err = 1'b0; dec_rdata[PW-1:0] = limit_sh[c]; wr_limit[c] = 1'b1; end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // One outstanding transaction: the response holds until the master takes it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dds_icb_rsp_valid <= 1'b0;
      dds_icb_rsp_err   <= 1'b0;
      dds_icb_rsp_rdata <= '0;
    end else if (accept) begin
      dds_icb_rsp_valid <= 1'b1;
      dds_icb_rsp_err   <= dec_err;
      dds_icb_rsp_rdata <= (dds_icb_cmd_read && !dec_err) ? dec_rdata : 32'h0;
    end else if (dds_icb_rsp_ready) begin
      dds_icb_rsp_valid <= 1'b0;
    end
  end

  // Shadow writes, APPLY commit and phase accumulation; a 0->1 EN commit reloads the start phase.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) begin
        ctrl_sh[c]  <= '0;
        ctrl_act[c] <= '0;
        freq_sh[c]  <= '0;
        freq_act[c] <= '0;
        phase_sh[c] <= '0;
        amp_sh[c]   <= AMP_ONE;
        amp_act[c]  <= AMP_ONE;
        acc[c]      <= '0;
`ifdef DDS_SWEEP_EN
        step_sh[c]   <= '0;
        step_act[c]  <= '0;
        limit_sh[c]  <= '0;
        limit_act[c] <= '0;
        freq_base[c] <= '0;
`endif
      end
`ifdef DDS_SWEEP_EN
      sweep_cnt <= '0;
`endif
    end else begin
`ifdef DDS_SWEEP_EN
      sweep_cnt <= sweep_cnt + 10'd1;
`endif
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && wr_ctrl[c])  ctrl_sh[c]  <= dds_icb_cmd_wdata[CW-1:0];
        if (wr_en && wr_freq[c])  freq_sh[c]  <= dds_icb_cmd_wdata[PW-1:0];
        if (wr_en && wr_phase[c]) phase_sh[c] <= dds_icb_cmd_wdata[PW-1:0];
        if (wr_en && wr_amp[c])   amp_sh[c]   <= dds_icb_cmd_wdata[DW:0];
`ifdef DDS_SWEEP_EN
        if (wr_en && wr_step[c])  step_sh[c]  <= dds_icb_cmd_wdata[PW-1:0];
        if (wr_en && wr_limit[c]) limit_sh[c] <= dds_icb_cmd_wdata[PW-1:0];
`endif
        if (commit[c]) begin
          ctrl_act[c] <= ctrl_sh[c];
          amp_act[c]  <= amp_sh[c];
          freq_act[c] <= freq_sh[c];
`ifdef DDS_SWEEP_EN
          step_act[c]  <= step_sh[c];
          limit_act[c] <= limit_sh[c];
          freq_base[c] <= freq_sh[c];
`endif
        end
`ifdef DDS_SWEEP_EN
        else if (sweep_tick && ctrl_act[c][0] && ctrl_act[c][3]) begin
          freq_act[c] <= sweep_wrap[c] ? freq_base[c] : freq_next[c];
        end
`endif
        if (commit[c] && ctrl_sh[c][0] && !ctrl_act[c][0]) acc[c] <= phase_sh[c];
        else if (ctrl_act[c][0])                            acc[c] <= acc[c] + freq_act[c];
      end
    end
  end

  function automatic logic [DW-1:0] wave_fn(input logic [PW-1:0] a, input logic [1:0] sel);
    logic [DW:0] p;
    p = a[PW-1 -: DW+1];
    case (sel)
      2'd0:    return p[DW:1];
      2'd1:    return p[DW] ? ~p[DW-1:0] : p[DW-1:0];
      2'd2:    return p[DW] ? {DW{1'b1}} : {DW{1'b0}};
      default: return {DW{1'b1}};
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      prod[c]   = {{(DW+1){1'b0}}, wave_q[c]} * {{DW{1'b0}}, amp_act[c]};
      scaled[c] = SW'(prod[c] >> DW);
    end
  end

  // Two output stages: waveform lookup, then gain with saturation.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) begin
        wave_q[c] <= '0;
        dac_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wave_q[c] <= ctrl_act[c][0] ? wave_fn(acc[c], ctrl_act[c][2:1]) : '0;
        dac_q[c]  <= scaled[c][DW] ? {DW{1'b1}} : scaled[c][DW-1:0];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_dac
    assign dac_data[c*DW +: DW] = dac_q[c];
  end

endmodule

// File: doc/icb_dds_multi.md
Name: icb_dds_multi

Overview:
Parametrised multi-channel DDS generator with an ICB slave register interface. Successor to the single-channel DDS top: NCH independent phase accumulators, each with its own frequency, phase offset, amplitude and waveform select. Double-buffered registers give glitch-free coherent updates. Sits on the core's ICB peripheral bus and drives one DAC data bus per channel.

Parameters:
NCH, 2, number of channels (1..8)
PW, 32, phase accumulator / frequency word width (16..32)
DW, 8, DAC sample width per channel (4..16)

Ports:
sys_clk  in  1  single clock for bus and DDS datapath
sys_rst  in  1  synchronous, active-high reset
dds_icb_cmd_valid  in  1  command valid
dds_icb_cmd_ready  out  1  command accepted
dds_icb_cmd_addr  in  32  byte address, addr[8:0] decoded
dds_icb_cmd_read  in  1  1=read, 0=write
dds_icb_cmd_wdata  in  32  write data
dds_icb_cmd_wmask  in  4  byte enables; ignored, full-word writes only
dds_icb_rsp_valid  out  1  response valid
dds_icb_rsp_ready  in  1  response accepted
dds_icb_rsp_err  out  1  decode error
dds_icb_rsp_rdata  out  32  read data
dac_data  out  NCH*DW  channel c in bits [c*DW +: DW]

Behaviour:
- Interface: one clock (sys_clk), reset synchronous active-high (sys_rst); all registers reset on the sys_clk edge with sys_rst=1.
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, dac_data=0; all shadow/active regs 0 except AMP=2^DW (unity gain).
- ICB: cmd_ready = ~rsp_valid | rsp_ready (one outstanding). Accept when valid&ready. Response registered 1 cycle after accept. rsp_valid holds until rsp_ready; rdata/err stable while held. Every write also gets a response (rdata=0).
- Address map, channel c at c*0x20 (c<NCH): 0x00 CTRL (bit0 EN, bits2:1 WAVE 0=saw 1=triangle 2=square 3=dc), 0x04 FREQ [PW-1:0], 0x08 PHASE [PW-1:0], 0x0C AMP [DW:0]. Global: 0x100 APPLY (write: bit c commits channel c; reads 0), 0x104 STATUS (read-only, bit c = active EN).
- Unmapped or c>=NCH address, or write to STATUS: rsp_err=1, no state change, rdata=0. Upper bits beyond field width read 0.
- Writes land in shadow regs; reads return shadow. Shadow -> active copy only on APPLY bit, the cycle after the APPLY write is accepted. Same-cycle APPLY on multiple channels commits simultaneously (phase-coherent).
- On commit: phase accumulator loads active PHASE if EN goes 0->1; otherwise keeps running with new FREQ (continuous phase).
- Accumulator: EN=1 -> acc <= acc + FREQ mod 2^PW every cycle; EN=0 -> acc holds, channel output forced 0.
- Waveform from p = (acc)[PW-1 -: DW+1]: saw = p[DW:1]; triangle = p[DW] ? ~p[DW-1:0] : p[DW-1:0]; square = p[DW] ? 2^DW-1 : 0; dc = 2^DW-1.
- Scaling: out = (wave*AMP) >> DW, saturated to 2^DW-1. AMP=0 -> 0.
- Latency: accumulator update -> dac_data is 2 registered stages (wave, scaled output).
- Reset mid-transaction: pending response dropped, rsp_valid=0 next cycle.

Optional Feature:
DDS_SWEEP_EN. Defined: per-channel 0x10 STEP (signed PW) and 0x14 LIMIT (PW), both shadowed/committed via APPLY; CTRL bit3 SWEEP. When SWEEP=1 and EN=1, active FREQ += STEP every 2^10 cycles; crossing LIMIT (above for STEP>0, below for STEP<0) reloads committed FREQ (sawtooth sweep). Undefined: 0x10/0x14 return rsp_err=1, CTRL bit3 reads 0, no sweep logic.

Test Plan:
- Reset, then read 0x0C ch0 -> rdata=0x100 (DW=8), err=0; dac_data=0.
- Ch0 FREQ=0x0100_0000, CTRL=0x1 (saw), AMP=0x100, APPLY=0x1 -> after latency dac_data[7:0] steps 0,0x01... ramp, period 256 cycles, increment 1 per cycle on p[8:1] bits.
- Ch0 square, AMP=0x80 -> levels 0 and 0x7F; AMP=0x1FF -> saturates at 0xFF.
- Ch0/ch1 same FREQ, PHASE 0 and 0x8000_0000, single APPLY=0x3 -> ch1 square is exact inverse of ch0 each cycle.
- Write FREQ without APPLY -> output unchanged, read-back shows new shadow; read 0x040 with NCH=2 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after read -> cmd_ready=0, rsp_valid/rdata stable; release -> next command accepted same cycle.
